byte_queue: RTL
===============

BYTE_QUEUE -- requirements
Module: byte_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 8, meaning number of byte entries (power of two, fixed at 8 for this release).
REQ-002 SHALL have port clock_100k  input  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port data_in  input  8  byte offered by the upstream deserializer.
REQ-005 SHALL have port enqueue_in  input  1  upstream byte-valid (deserializer data_ready), level, held until acknowledged.
REQ-006 SHALL have port ack_out  output  1  acknowledge to upstream (deserializer ack_in), registered.
REQ-007 SHALL have port dequeue_in  input  1  downstream pop request, sampled each edge.
REQ-008 SHALL have port data_out  output  8  last popped byte, registered.
REQ-009 SHALL have port valid_out  output  1  one-cycle pulse marking a new data_out.
REQ-010 SHALL have port len_out  output  4  occupancy, 0..8.
REQ-011 SHALL have ports full_out / empty_out  output  1 each  len_out==8 / len_out==0.
REQ-012 SHALL have port underflow_out  output  1  sticky flag, pop attempted while empty.

Function
REQ-013 SHALL store bytes in an 8x8 register array with 3-bit write and read pointers that wrap 7->0.
REQ-014 SHALL run an enqueue FSM with states WAIT, ACK, RELEASE.
REQ-015 In WAIT, when enqueue_in=1 and full_out=0 at an edge, SHALL write data_in at wr_ptr, increment wr_ptr, set ack_out=1, and go to ACK.
REQ-016 In WAIT with full_out=1, SHALL not write, SHALL keep ack_out=0, and SHALL stay in WAIT (upstream stalls).
REQ-017 In ACK, SHALL clear ack_out (one-cycle pulse), ignore enqueue_in, and go to RELEASE.
REQ-018 In RELEASE, SHALL stay until enqueue_in=0 is sampled, then go to WAIT; no write while in ACK or RELEASE (no double capture).
REQ-019 When dequeue_in=1 and empty_out=0 at an edge, SHALL load data_out from mem[rd_ptr], increment rd_ptr, and pulse valid_out=1 for exactly one cycle.
REQ-020 When dequeue_in=1 and empty_out=1, SHALL leave data_out unchanged, keep valid_out=0, and set underflow_out=1 until reset.
REQ-021 Full/empty for the write decision SHALL be evaluated on pre-edge occupancy; a same-edge pop SHALL NOT enable a write when full.
REQ-022 A write and a pop on the same edge SHALL both occur, leaving len_out unchanged.
REQ-023 len_out, full_out and empty_out SHALL be registered and consistent with the pointers on the same cycle.
REQ-024 A pop on an entry written on the same edge SHALL NOT be possible (empty evaluated pre-edge); first-write-to-read latency SHALL be 1 edge minimum.

Reset
REQ-025 reset=1 SHALL immediately force FSM=WAIT, pointers=0, len_out=0, empty_out=1, full_out=0, ack_out=0, data_out=0x00, valid_out=0, underflow_out=0, and the array to 0x00, regardless of operation in progress.

Verification
REQ-026 Single byte: enqueue_in=1, data_in=0xA5 -> ack_out high exactly one cycle after the edge, len_out=1; hold enqueue_in 2 further cycles -> no second write; dequeue_in pulse -> data_out=0xA5, valid_out one cycle, empty_out=1.
REQ-027 Fill: enqueue 0x01..0x08 -> full_out=1, len_out=8; offer 0x09 held -> ack_out stays 0; pop -> data_out=0x01, then 0x09 acknowledged next edge, len_out=8.
REQ-028 Wrap: enqueue/pop 12 bytes 0x10..0x1B interleaved -> popped in identical order, pointers wrap, len_out returns 0.
REQ-029 Simultaneous: len_out=3, write 0x55 and pop on the same edge -> len_out=3, data_out = oldest byte, 0x55 popped fourth.
REQ-030 Empty pop: dequeue_in=1 with len_out=0 -> valid_out=0, data_out unchanged, underflow_out=1 and stays 1.
REQ-031 Reset mid-operation: len_out=5 with ack_out=1, assert reset between edges -> all outputs per REQ-025 immediately; subsequent enqueue of 0x3C pops as 0x3C.

Source files
------------

// File: rtl/byte_queue.sv
// Eight-entry byte FIFO between the deserializer and its consumer.
// Upstream uses a level/ack handshake; downstream pops with a strobe.
module byte_queue #(
    parameter int DEPTH = 8
) (
    input  logic       clock_100k,
    input  logic       reset,
    input  logic [7:0] data_in,
    input  logic       enqueue_in,
    output logic       ack_out,
    input  logic       dequeue_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic [3:0] len_out,
    output logic       full_out,
    output logic       empty_out,
    output logic       underflow_out
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_WAIT,
        S_ACK,
        S_RELEASE
    } state_e;

    state_e          state_q, state_d;
    logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [3:0]      len_q, len_d;
    logic            full_q, full_d;
    logic            empty_q, empty_d;
    logic            ack_q, ack_d;
    logic [7:0]      data_q, data_d;
    logic            valid_q, valid_d;
    logic            under_q, under_d;
    logic [7:0]      mem_q [DEPTH];
    logic [7:0]      mem_d [DEPTH];

    logic            do_write;
    logic            do_pop;

    // Both decisions use pre-edge flags, so a same-edge pop never frees a slot
    // for the write, and a same-edge write is never visible to the pop.
    assign do_write = (state_q == S_WAIT) && enqueue_in && !full_q;
    assign do_pop   = dequeue_in && !empty_q;

    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        len_d    = len_q;
        data_d   = data_q;
        mem_d    = mem_q;
        ack_d    = do_write;
        valid_d  = do_pop;
        under_d  = under_q | (dequeue_in & empty_q);

        unique case (state_q)
            S_WAIT:    if (do_write) state_d = S_ACK;
            S_ACK:     state_d = S_RELEASE;
            S_RELEASE: if (!enqueue_in) state_d = S_WAIT;
            default:   state_d = S_WAIT;
        endcase

        if (do_write) begin
            mem_d[wr_ptr_q] = data_in;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end

        if (do_pop) begin
            data_d   = mem_q[rd_ptr_q];
            rd_ptr_d = rd_ptr_q + 1'b1;
        end

        if (do_write && !do_pop) begin
            len_d = len_q + 4'd1;
        end else if (!do_write && do_pop) begin
            len_d = len_q - 4'd1;
        end

        full_d  = (len_d == 4'(DEPTH));
        empty_d = (len_d == 4'd0);
    end

    always_ff @(posedge clock_100k or posedge reset) begin
        if (reset) begin
            state_q  <= S_WAIT;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            len_q    <= 4'd0;
            full_q   <= 1'b0;
            empty_q  <= 1'b1;
            ack_q    <= 1'b0;
            data_q   <= 8'h00;
            valid_q  <= 1'b0;
            under_q  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 8'h00;
            end
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            len_q    <= len_d;
            full_q   <= full_d;
            empty_q  <= empty_d;
            ack_q    <= ack_d;
            data_q   <= data_d;
            valid_q  <= valid_d;
            under_q  <= under_d;
            mem_q    <= mem_d;
        end
    end

    assign ack_out       = ack_q;
    assign data_out      = data_q;
    assign valid_out     = valid_q;
    assign len_out       = len_q;
    assign full_out      = full_q;
    assign empty_out     = empty_q;
    assign underflow_out = under_q;

endmodule
